// File: rtl/pwm_basico.sv
// pwm_basico: free-running PWM whose duty cycle follows a 36-step sine table
// Ports:
//    clk     - system clock, all state updates on the rising edge
//    reset   - asynchronous active-low reset
//    pwm_out - registered PWM output, high while cnt < duty (one clk late)
// Parameters: R period counter bits (>= 6), N clk per tick, HOLD periods per sample
module pwm_basico #(
   parameter int R    = 6,
   parameter int N    = 1600,
   parameter int HOLD = 8
) (
   input  logic clk,
   input  logic reset,
   output logic pwm_out
);
   localparam int PW = N > 1 ? $clog2(N) : 1;
   localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
   localparam logic [5:0] LUT [0:35] = '{
      6'd32, 6'd37, 6'd43, 6'd48, 6'd52, 6'd56, 6'd59, 6'd61, 6'd63,
      6'd63, 6'd63, 6'd61, 6'd59, 6'd56, 6'd52, 6'd48, 6'd43, 6'd37,
      6'd32, 6'd27, 6'd21, 6'd16, 6'd12, 6'd8,  6'd5,  6'd3,  6'd1,
      6'd1,  6'd1,  6'd3,  6'd5,  6'd8,  6'd12, 6'd16, 6'd21, 6'd27
   };
   logic [PW-1:0] pre;
   logic [R-1:0]  cnt;
   logic [HW-1:0] h;
   logic [5:0]    idx;
   logic [R-1:0]  duty;
   logic          tick;
   logic          pend;
   logic          hwrap;
   logic [5:0]    idx_nxt;
   always_comb begin
      tick    = pre == PW'(N - 1);
      pend    = tick && cnt == '1;
      hwrap   = h == HW'(HOLD - 1);
      idx_nxt = pend && hwrap ? (idx == 6'd35 ? 6'd0 : idx + 6'd1) : idx;
   end
   // duty is reloaded only at period ends so a period never sees two duty values
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre     <= '0;
         cnt     <= '0;
         h       <= '0;
         idx     <= '0;
         duty    <= R'(LUT[0]) << (R - 6);
         pwm_out <= 1'b0;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick)
            cnt <= cnt + 1'b1;
         if (pend) begin
            h    <= hwrap ? '0 : h + 1'b1;
            idx  <= idx_nxt;
            duty <= R'(LUT[idx_nxt]) << (R - 6);
         end
         pwm_out <= cnt < duty;
      end
   end
endmodule

// File: tb/tb_pwm_basico.sv
// tb_pwm_basico: randomized reset/run checks of pwm_basico against an elapsed-time model
module tb_pwm_basico;
   localparam int R    = 6;
   localparam int N    = 3;
   localparam int HOLD = 2;
   localparam int PER  = 64 * N;
   logic clk = 1'b0;
   logic reset;
   logic pwm_out;
   int   checks = 0;
   int   errors = 0;
   int   t;
   int   hi;
   int   lut [36] = '{32, 37, 43, 48, 52, 56, 59, 61, 63,
                      63, 63, 61, 59, 56, 52, 48, 43, 37,
                      32, 27, 21, 16, 12,  8,  5,  3,  1,
                       1,  1,  3,  5,  8, 12, 16, 21, 27};

   pwm_basico #(.R(R), .N(N), .HOLD(HOLD)) dut (
      .clk(clk),
      .reset(reset),
      .pwm_out(pwm_out)
   );

   always #5 clk = ~clk;

   // duty in force after c clk edges since release, from elapsed time alone
   function automatic int duty_at(int c);
      return lut[((c / PER) / HOLD) % 36];
   endfunction

   function automatic logic exp_at(int c);
      return ((c / N) % 64) < duty_at(c);
   endfunction

   task automatic check_low(string tag);
      checks++;
      assert (pwm_out === 1'b0) else begin
         errors++;
         $error("FAIL %s t=%0d observed %b expected 0", tag, t, pwm_out);
      end
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         t++;
         checks++;
         assert (pwm_out === exp_at(t - 1)) else begin
            errors++;
            $error("FAIL out t=%0d observed %b expected %b", t, pwm_out, exp_at(t - 1));
         end
         hi += int'(pwm_out === 1'b1);
         if (t % PER == 0) begin
            checks++;
            assert (hi === duty_at(t - 1) * N) else begin
               errors++;
               $error("FAIL high_time period=%0d observed %0d expected %0d", t / PER - 1, hi, duty_at(t - 1) * N);
            end
            hi = 0;
         end
      end
   endtask

   task automatic mid_reset(int hold_edges);
      #2;
      reset = 1'b0;
      #1;
      check_low("async_reset");
      for (int i = 0; i < hold_edges; i++) begin
         @(posedge clk);
         #1;
         check_low("in_reset");
      end
      reset = 1'b1;
      t = 0;
      hi = 0;
   endtask

   initial begin
      t = 0;
      hi = 0;
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      check_low("reset_t0");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_low("reset_hold");
      end
      reset = 1'b1;
      run(36 * HOLD * PER + 3 * PER);
      mid_reset(3);
      run(5 * HOLD * PER + PER / 2 + 7);
      mid_reset(2);
      for (int k = 0; k < 3; k++) begin
         run(int'($urandom_range(50, 6000)));
         mid_reset(int'($urandom_range(1, 4)));
      end
      run(3 * PER);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pwm_basico.md
# pwm_basico

Free-running PWM generator with an on-chip sine-modulated duty cycle. A prescaler divides the system clock, an R-bit period counter produces the PWM carrier, and a 36-entry sine table sweeps the duty cycle through one full sine cycle in 10° steps. It needs no control inputs, so it can drive an LED or filter stage directly as a demo or test source.

## Interface
- R, default 6: period counter resolution in bits; PWM period = 2^R ticks; R ≥ 6.
- N, default 1600: prescaler ratio; one tick every N clk cycles; N ≥ 1.
- HOLD, default 8: PWM periods each sine sample is held; HOLD ≥ 1.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pwm_out  output  1  registered PWM output.

## Operation
- Prescaler `pre`, 0..N-1: increments every clk and wraps N-1→0. A tick occurs on the cycle where pre == N-1.
- Period counter `cnt`, R bits, 0..2^R-1: increments on each tick and wraps 2^R-1→0.
- A period end is a tick with cnt == 2^R-1.
- Hold counter `h`, 0..HOLD-1: increments at each period end and wraps HOLD-1→0.
- Sample index `idx`, 0..35: increments at a period end when h == HOLD-1, wrapping 35→0.
- Duty register `duty`, R bits: at each period end it loads LUT[idx_next] << (R-6), where idx_next is the index value after this period end's update.
  - Duty changes only at period boundaries, so no glitch occurs inside a period.
- Sine LUT, 6-bit values, each 32 + round(31·sin(k·10°)) with ties rounded away from zero. For k = 0..35:
  - 32, 37, 43, 48, 52, 56, 59, 61, 63,
  - 63, 63, 61, 59, 56, 52, 48, 43, 37,
  - 32, 27, 21, 16, 12, 8, 5, 3, 1,
  - 1, 1, 3, 5, 8, 12, 16, 21, 27.
- Output: every clk, pwm_out <= (cnt < duty), unsigned compare.
  - High time per period = duty·N clk cycles.
  - duty = 0 never occurs; LUT minimum is 1, so no period is fully low.
  - Maximum duty is 63 of 64, so the output is never high for a whole period.

## Timing
- Reset asserted (reset = 0), asynchronously: pre = 0, cnt = 0, h = 0, idx = 0, duty = LUT[0] << (R-6) (32 for R = 6), pwm_out = 0.
- First clk edge after release: pwm_out = 1 (cnt 0 < duty).
- pwm_out lags the (cnt, duty) compare by exactly one clk.
- PWM period = 2^R·N clk = 102400 clk at defaults (2.048 ms at 50 MHz).
- Sample hold time = HOLD periods = 819200 clk at defaults.
- Full sine cycle = 36·HOLD·2^R·N clk = 2^(R+3)·36·N clk at defaults = 29,491,200 clk.
- Reset mid-operation: all state returns immediately to reset values regardless of pre/cnt/h/idx. After release the sequence restarts from sample 0 with a full HOLD count.
- No clock enable; the block runs continuously once out of reset.

## Test plan
- Reset: hold reset = 0 for several clk with the clock running → pwm_out = 0 throughout. Release → pwm_out = 1 after the first rising edge.
- Sample 0: at defaults, measure periods 0..7 → each period is 102400 clk, high 51200 clk (duty 32), low 51200.
- Transition: period 8 → high 59200 clk (duty 37). Period 16 → high 68800 (duty 43). Edges stay aligned to period starts, with no runt pulses.
- Extremes: periods of idx 8–10 → high 100800, low 1600 (duty 63). Periods of idx 26–28 → high 1600, low 100800 (duty 1).
- Wrap: after 288 periods (29,491,200 clk) → idx returns to 0 and the next 8 periods are high 51200 again. The sequence repeats identically.
- Async reset mid-period: assert reset = 0 between clk edges during idx 5 → pwm_out = 0 immediately, without waiting for a clk edge. After release, periods resume at duty 32 with an 8-period hold.
- Reduced-parameter variant (N = 2, HOLD = 1) to shorten the run → duty sequence equals the LUT in order, one entry per 128-clk period.
